// File: rtl/instr_fetch_assembler_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding and
// the group-5 (two-word instruction) identifier, which the decoder package
// also uses so that fetch and decode agree on what a long instruction is.
package pkg_instr_fetch;

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    HOLD     = 2'd2,
    DISCARD  = 2'd3
  } fetch_state_e;

  // Group field lives in bits [15:10] of the first instruction word.
  localparam int unsigned GROUP_MSB = 15;
  localparam int unsigned GROUP_LSB = 10;
  localparam logic [5:0]  GROUP5_ID = 6'b111000;

  // True when the first word of an instruction announces a second word.
  function automatic logic is_group5(input logic [15:0] word);
    return (word[GROUP_MSB:GROUP_LSB] == GROUP5_ID);
  endfunction

endpackage

// File: rtl/instr_fetch_assembler_length_detect.sv
// Combinational length detector: flags group-5 first words, which are
// followed by a second instruction word. All other encodings, including
// unknown groups, are treated as one-word instructions.
module instr_length_detect
  import pkg_instr_fetch::*;
(
  input  logic [15:0] word,
  output logic        is_long
);

  assign is_long = is_group5(word);

endmodule

// File: rtl/instr_fetch_assembler.sv
// Instruction fetch/assemble stage. Fetches one or two 16-bit words from
// instruction memory over req/ack, assembles them into a complete
// instruction and hands it to decode over valid/ready. No prefetch: a new
// fetch starts only after the held instruction is accepted or dropped.
// Redirects flush whatever is in flight; a request already presented to
// memory is never withdrawn, it is drained in DISCARD and its data dropped.
module instr_fetch_assembler
  import pkg_instr_fetch::*;
#(
  parameter int unsigned            ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction memory
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_rdata,
  // redirect from control
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  // assembled instruction to decode
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           instr_hi,
  output logic [15:0]           instr_lo,
  output logic                  instr_is_long,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  fetch_state_e          state_q,        state_d;
  logic [ADDR_WIDTH-1:0] pc_q,           pc_d;
  logic [ADDR_WIDTH-1:0] discard_addr_q, discard_addr_d;
  logic [15:0]           instr_hi_q,     instr_hi_d;
  logic [15:0]           instr_lo_q,     instr_lo_d;
  logic                  is_long_q,      is_long_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q,     instr_pc_d;

  logic                  rdata_is_long;

  instr_length_detect u_len (
    .word    (mem_rdata),
    .is_long (rdata_is_long)
  );

  // Next-state and datapath update; redirect overrides everything else.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    discard_addr_d = discard_addr_q;
    instr_hi_d     = instr_hi_q;
    instr_lo_d     = instr_lo_q;
    is_long_d      = is_long_q;
    instr_pc_d     = instr_pc_q;

    case (state_q)
      FETCH_HI: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (mem_ack) begin
            state_d = FETCH_HI;
          end else begin
            // Request is outstanding: remember where it went and drain it.
            discard_addr_d = pc_q;
            state_d        = DISCARD;
          end
        end else if (mem_ack) begin
          instr_hi_d = mem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + PC_ONE;
          if (rdata_is_long) begin
            is_long_d = 1'b1;
            state_d   = FETCH_LO;
          end else begin
            instr_lo_d = 16'h0000;
            is_long_d  = 1'b0;
            state_d    = HOLD;
          end
        end
      end

      FETCH_LO: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (mem_ack) begin
            state_d = FETCH_HI;
          end else begin
            discard_addr_d = pc_q;
            state_d        = DISCARD;
          end
        end else if (mem_ack) begin
          instr_lo_d = mem_rdata;
          pc_d       = pc_q + PC_ONE;
          state_d    = HOLD;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          // Held instruction is dropped even if decode is ready this cycle.
          pc_d    = redirect_pc;
          state_d = FETCH_HI;
        end else if (out_ready) begin
          state_d = FETCH_HI;
        end
      end

      DISCARD: begin
        if (redirect_valid) begin
          // Newer target wins; the abandoned request is still being drained.
          pc_d    = redirect_pc;
          state_d = DISCARD;
        end else if (mem_ack) begin
          state_d = FETCH_HI;
        end
      end

      default: begin
        state_d = FETCH_HI;
      end
    endcase
  end

  // State and instruction registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FETCH_HI;
      pc_q           <= RESET_PC;
      discard_addr_q <= RESET_PC;
      instr_hi_q     <= 16'h0000;
      instr_lo_q     <= 16'h0000;
      is_long_q      <= 1'b0;
      instr_pc_q     <= RESET_PC;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      discard_addr_q <= discard_addr_d;
      instr_hi_q     <= instr_hi_d;
      instr_lo_q     <= instr_lo_d;
      is_long_q      <= is_long_d;
      instr_pc_q     <= instr_pc_d;
    end
  end

  // Request is gated by rst_n so memory sees no request while in reset.
  assign mem_req       = rst_n && (state_q != HOLD);
  assign mem_addr      = (state_q == DISCARD) ? discard_addr_q : pc_q;

  // out_valid is a pure decode of the registered state.
  assign out_valid     = (state_q == HOLD);
  assign instr_hi      = instr_hi_q;
  assign instr_lo      = instr_lo_q;
  assign instr_is_long = is_long_q;
  assign instr_pc      = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_assembler.sv
// Directed bench for instr_fetch_assembler: table of single-instruction
// fetches plus hand-written reset, stall, redirect-while-waiting and
// reset-mid-fetch sequences against a behavioural memory with settable
// ack latency.
module tb_instr_fetch_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] instr_hi;
  logic [15:0] instr_lo;
  logic        instr_is_long;
  logic [15:0] instr_pc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_assembler #(
    .ADDR_WIDTH (16),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .instr_hi       (instr_hi),
    .instr_lo       (instr_lo),
    .instr_is_long  (instr_is_long),
    .instr_pc       (instr_pc)
  );

  // Behavioural memory: ack after lat wait cycles of an unbroken request.
  logic [15:0] mem [0:65535];
  int lat = 0;
  int wait_cnt = 0;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (wait_cnt == lat);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  typedef struct {
    logic [15:0] start_pc;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] exp_hi;
    logic [15:0] exp_lo;
    logic        exp_long;
    logic [15:0] exp_next;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [15:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  // Cycles until out_valid is seen, capped at 20.
  task automatic wait_valid(output int steps);
    steps = 0;
    while (!out_valid && steps < 20) begin
      step();
      steps++;
    end
  endtask

  initial begin
    int          steps;
    int          n;
    int          held;
    logic        bad_addr;
    logic        seen_valid;
    logic [15:0] a1;

    vecs[0] = '{16'h0010, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 1'b0, 16'h0011, 1};
    vecs[1] = '{16'h0004, 16'hE0A5, 16'hBEEF, 16'hE0A5, 16'hBEEF, 1'b1, 16'h0006, 2};
    vecs[2] = '{16'h0020, 16'hE3FF, 16'h5555, 16'hE3FF, 16'h5555, 1'b1, 16'h0022, 2};
    vecs[3] = '{16'h0030, 16'hE400, 16'hDEAD, 16'hE400, 16'h0000, 1'b0, 16'h0031, 1};
    vecs[4] = '{16'h0040, 16'hFC00, 16'h1111, 16'hFC00, 16'h0000, 1'b0, 16'h0041, 1};
    vecs[5] = '{16'hFFFF, 16'hE000, 16'h0042, 16'hE000, 16'h0042, 1'b1, 16'h0001, 2};
    vecs[6] = '{16'hFFFF, 16'h7777, 16'h0099, 16'h7777, 16'h0000, 1'b0, 16'h0000, 1};

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1234;
    mem[1] = 16'h0001;

    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    lat            = 0;

    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_mem_req",   32'(mem_req),   32'h0);
    chk("rst_instr_hi",  32'(instr_hi),  32'h0);
    chk("rst_instr_lo",  32'(instr_lo),  32'h0);
    chk("rst_is_long",   32'(instr_is_long), 32'h0);
    chk("rst_instr_pc",  32'(instr_pc),  32'h0);
    step();
    step();

    // First fetch after release, zero-wait memory, decode always ready
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rel_mem_req",  32'(mem_req),  32'h1);
    chk("rel_mem_addr", 32'(mem_addr), 32'h0);
    step();
    chk("first_valid",   32'(out_valid), 32'h1);
    chk("first_hi",      32'(instr_hi),  32'h1234);
    chk("first_lo",      32'(instr_lo),  32'h0);
    chk("first_long",    32'(instr_is_long), 32'h0);
    chk("first_pc",      32'(instr_pc),  32'h0);
    step();
    out_ready = 1'b0;
    chk("first_drop",    32'(out_valid), 32'h0);
    chk("first_next",    32'(mem_addr),  32'h1);

    // Table of single-instruction fetches started by redirect
    for (int i = 0; i < 7; i++) begin
      mem[vecs[i].start_pc] = vecs[i].w0;
      a1 = vecs[i].start_pc + 16'h0001;
      mem[a1] = vecs[i].w1;
      do_redirect(vecs[i].start_pc);
      wait_valid(steps);
      chk($sformatf("v%0d_latency", i), 32'(steps), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_hi", i),   32'(instr_hi),      32'(vecs[i].exp_hi));
      chk($sformatf("v%0d_lo", i),   32'(instr_lo),      32'(vecs[i].exp_lo));
      chk($sformatf("v%0d_long", i), 32'(instr_is_long), 32'(vecs[i].exp_long));
      chk($sformatf("v%0d_pc", i),   32'(instr_pc),      32'(vecs[i].start_pc));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("v%0d_drop", i), 32'(out_valid), 32'h0);
      chk($sformatf("v%0d_next", i), 32'(mem_addr),  32'(vecs[i].exp_next));
    end

    // Back-pressure: held instruction stays put, no request, no advance
    mem[16'h0050] = 16'h2222;
    do_redirect(16'h0050);
    wait_valid(steps);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'h1);
      chk($sformatf("stall%0d_req", k),   32'(mem_req),   32'h0);
      chk($sformatf("stall%0d_hi", k),    32'(instr_hi),  32'h2222);
      chk($sformatf("stall%0d_addr", k),  32'(mem_addr),  32'h0051);
      step();
    end
    out_ready = 1'b1;
    chk("stall_6th_valid", 32'(out_valid), 32'h1);
    step();
    out_ready = 1'b0;
    chk("stall_xfer_drop", 32'(out_valid), 32'h0);
    chk("stall_xfer_req",  32'(mem_req),   32'h1);
    chk("stall_xfer_addr", 32'(mem_addr),  32'h0051);

    // Slow memory: redirect on the first wait cycle of FETCH_LO
    wait_valid(steps);
    lat = 3;
    mem[16'h0060] = 16'hE111;
    mem[16'h0061] = 16'hAAAA;
    mem[16'h0100] = 16'h0333;
    do_redirect(16'h0060);
    n = 0;
    seen_valid = 1'b0;
    while (!(mem_req && mem_addr == 16'h0061) && n < 20) begin
      if (out_valid) seen_valid = 1'b1;
      step();
      n++;
    end
    chk("lo_reached_addr", 32'(mem_addr), 32'h0061);
    chk("lo_first_no_ack", 32'(mem_ack),  32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    step();
    redirect_valid = 1'b0;
    n = 0;
    held = 0;
    bad_addr = 1'b0;
    while (mem_addr != 16'h0100 && n < 20) begin
      if (mem_req && mem_addr == 16'h0061) held++;
      else bad_addr = 1'b1;
      if (out_valid) seen_valid = 1'b1;
      step();
      n++;
    end
    chk("discard_held_cycles", 32'(held),     32'd3);
    chk("discard_addr_ok",     32'(bad_addr), 32'h0);
    chk("discard_no_valid",    32'(seen_valid), 32'h0);
    chk("redirect_req_addr",   32'(mem_addr), 32'h0100);
    wait_valid(steps);
    chk("redirect_latency", 32'(steps),         32'd4);
    chk("redirect_hi",      32'(instr_hi),      32'h0333);
    chk("redirect_pc",      32'(instr_pc),      32'h0100);
    chk("redirect_long",    32'(instr_is_long), 32'h0);

    // Reset pulse while FETCH_LO waits on memory
    mem[16'h0070] = 16'hE222;
    mem[16'h0071] = 16'h4444;
    mem[0] = 16'h1234;
    mem[1] = 16'h0001;
    do_redirect(16'h0070);
    n = 0;
    while (!(mem_req && mem_addr == 16'h0071) && n < 20) begin
      step();
      n++;
    end
    chk("rstlo_reached_addr", 32'(mem_addr), 32'h0071);
    rst_n = 1'b0;
    #1;
    chk("rstlo_out_valid", 32'(out_valid),     32'h0);
    chk("rstlo_instr_pc",  32'(instr_pc),      32'h0);
    chk("rstlo_is_long",   32'(instr_is_long), 32'h0);
    chk("rstlo_mem_req",   32'(mem_req),       32'h0);
    step();
    lat   = 0;
    rst_n = 1'b1;
    #1;
    chk("rstlo_restart_req",  32'(mem_req),  32'h1);
    chk("rstlo_restart_addr", 32'(mem_addr), 32'h0);
    wait_valid(steps);
    chk("rstlo_latency", 32'(steps),    32'd1);
    chk("rstlo_hi",      32'(instr_hi), 32'h1234);
    chk("rstlo_pc",      32'(instr_pc), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_assembler.md
Name: instr_fetch_assembler

Overview:
- Fetch stage sitting directly upstream of the instruction group decoders.
- Reads 16-bit instruction words from instruction memory over a req/ack handshake and detects group-5 two-word instructions from the first word.
- Presents a complete instruction (instr_hi, plus instr_lo for group 5) and its PC to the decode/control stage over a valid/ready handshake.
- Accepts branch/call/return redirects from the control stage.

Parameters:
- ADDR_WIDTH, 16, width of PC and memory word address (word-addressed; PC increments by 1 per 16-bit word).
- RESET_PC, 16'h0000, PC loaded on reset.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_WIDTH  word address; stable while mem_req=1 and mem_ack=0.
- mem_ack  in  1  read data valid this cycle; may arrive in the same cycle as mem_req.
- mem_rdata  in  16  read data, sampled when mem_req & mem_ack.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_WIDTH  new fetch address.
- out_valid  out  1  instruction available.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- instr_hi  out  16  first instruction word.
- instr_lo  out  16  second word; valid only when instr_is_long=1, 16'h0000 otherwise.
- instr_is_long  out  1  instruction is group 5 (two words).
- instr_pc  out  ADDR_WIDTH  address of instr_hi.

Behaviour:
- Reset (async assert, sync release):
  - state=FETCH_HI, pc=RESET_PC, discard=0.
  - out_valid=0, instr_hi=0, instr_lo=0, instr_is_long=0, instr_pc=RESET_PC.
  - mem_req is 0 while rst_n=0 and 1 from the first cycle after release.
- States:
  - FETCH_HI: mem_req=1, mem_addr=pc. On ack: instr_hi<=rdata, instr_pc<=pc, pc<=pc+1.
    - If rdata[15:10]==6'b111000 (group 5): instr_is_long<=1, go FETCH_LO.
    - Else: instr_lo<=0, instr_is_long<=0, go HOLD.
  - FETCH_LO: mem_req=1, mem_addr=pc. On ack: instr_lo<=rdata, pc<=pc+1, go HOLD.
  - HOLD: mem_req=0, out_valid=1. Outputs stable until transfer. On out_ready: go FETCH_HI.
  - DISCARD: mem_req=1, mem_addr held at the abandoned address. On ack: drop data, go FETCH_HI (pc already = redirect target).
- out_valid=1 only in HOLD; it is a registered state decode, not combinational from inputs.
- Latency with zero-wait memory (same-cycle ack):
  - One-word instruction: out_valid 1 cycle after entering FETCH_HI.
  - Two-word instruction: out_valid 2 cycles after entering FETCH_HI.
- No prefetch: the next fetch starts the cycle after transfer. Peak throughput is 1 one-word instruction per 2 cycles.
- Redirect (highest priority, any state): pc<=redirect_pc and out_valid drops next cycle.
  - FETCH_HI/FETCH_LO with mem_ack=0 same cycle: the request is outstanding and must not be withdrawn, so go DISCARD.
  - FETCH_HI/FETCH_LO with mem_ack=1 same cycle: data ignored, go FETCH_HI.
  - HOLD: held instruction dropped even if out_ready=1 same cycle (no transfer counted), go FETCH_HI.
  - DISCARD: pc updated to the newer target, remain in DISCARD.
- PC arithmetic is modulo 2^ADDR_WIDTH: pc=16'hFFFF wraps to 16'h0000. A group-5 instruction may straddle the wrap.
- Reset mid-transaction: state returns to FETCH_HI immediately. Memory must tolerate abandonment of the outstanding request on reset.
- Unknown group encodings are passed through as one-word instructions. The decoder flags them.

Decomposition:
- Package pkg_instr_fetch holds:
  - enum fetch_state {FETCH_HI, FETCH_LO, HOLD, DISCARD};
  - the group-5 identifier constant (6'b111000, bits 15:10), shared with the instruction decoder package so both agree.
- One combinational sub-module, instr_length_detect: input 16-bit word, output is_long. Reused by the assembler disassembly checker.

Test Plan:
- Reset, RESET_PC=0, mem[0]=16'h1234, zero-wait ack, out_ready=1 -> out_valid once, instr_hi=16'h1234, instr_is_long=0, instr_lo=0, instr_pc=0, next mem_addr=1.
- mem[4]=16'hE0A5, mem[5]=16'hBEEF, start pc=4 -> instr_hi=16'hE0A5, instr_lo=16'hBEEF, instr_is_long=1, instr_pc=4, next fetch addr=6.
- out_ready=0 for 5 cycles while out_valid=1 -> outputs stable, mem_req=0, no address advance; transfer on the 6th cycle.
- Memory with 3-cycle ack latency, redirect_valid with redirect_pc=16'h0100 on the first wait cycle of FETCH_LO -> mem_addr held until ack, that data dropped, next request to 16'h0100, no out_valid for the old instruction.
- pc=16'hFFFF holding 16'hE000, mem[0]=16'h0042 -> instr_pc=16'hFFFF, instr_lo=16'h0042, next fetch addr=16'h0001.
- rst_n pulsed low mid FETCH_LO -> out_valid=0, instr_pc=RESET_PC immediately; fetch restarts at RESET_PC after release.
